// File: rtl/lsu_dm_pkg.sv
// Shared control encodings for the data-memory port.
// Access size/sign codes plus lane helpers used by the LSU.
package lsu_dm_pkg;

  typedef enum logic [2:0] {
    DM_W  = 3'b000,
    DM_H  = 3'b001,
    DM_HU = 3'b010,
    DM_B  = 3'b011,
    DM_BU = 3'b100
  } dm_type_e;

  // Everything captured at accept time and replayed on the bus.
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [1:0]  off;
    logic [2:0]  typ;
  } dm_txn_t;

  function automatic logic dm_legal(
    input logic [2:0] t,
    input logic [1:0] off
  );
    logic ok;
    case (t)
      DM_W:        ok = (off == 2'b00);
      DM_H, DM_HU: ok = ~off[0];
      DM_B, DM_BU: ok = 1'b1;
      default:     ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] dm_be(
    input logic [2:0] t,
    input logic [1:0] off
  );
    logic [3:0] be;
    case (t)
      DM_W:        be = 4'b1111;
      DM_H, DM_HU: be = 4'b0011 << off;
      DM_B, DM_BU: be = 4'b0001 << off;
      default:     be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] dm_wrep(
    input logic [2:0]  t,
    input logic [31:0] d
  );
    logic [31:0] r;
    case (t)
      DM_H, DM_HU: r = {2{d[15:0]}};
      DM_B, DM_BU: r = {4{d[7:0]}};
      default:     r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_dm_port_ext.sv
// Load lane extraction and sign/zero extension.
// Purely combinational; offset picks the lane.
module dm_load_ext
  import lsu_dm_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  dm_type,
  output logic [31:0] result
);

  logic [7:0]  b;
  logic [15:0] h;

  // Select the addressed byte and halfword lanes.
  always_comb begin
    b = word[7:0];
    unique case (offset)
      2'd0: b = word[7:0];
      2'd1: b = word[15:8];
      2'd2: b = word[23:16];
      2'd3: b = word[31:24];
      default: b = word[7:0];
    endcase
    h = offset[1] ? word[31:16] : word[15:0];
  end

  // Extend the selected lane according to the access type.
  always_comb begin
    result = word;
    case (dm_type)
      DM_H:    result = {{16{h[15]}}, h};
      DM_HU:   result = {16'h0, h};
      DM_B:    result = {{24{b[7]}}, b};
      DM_BU:   result = {24'h0, b};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/lsu_dm_port.sv
// LSU data-memory port: one access at a time over a
// req/ack bus, with alignment checks and timeout.
module lsu_dm_port
  import lsu_dm_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        mem_r,
  input  logic        mem_w,
  input  logic [2:0]  dm_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  dm_txn_t       txn_q, txn_d;

  logic          access;
  logic          legal;
  logic [31:0]   ext;

  assign access = req_valid & (mem_r | mem_w);
  assign legal  = dm_legal(dm_type, addr[1:0]);

  dm_load_ext u_ext (
    .word    (bus_rdata),
    .offset  (txn_q.off),
    .dm_type (txn_q.typ),
    .result  (ext)
  );

  // Register all state; reset clears the bus bundle too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      txn_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      txn_q   <= txn_d;
    end
  end

  // Next state, capture, and handshake outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = 1'b0;
    txn_d    = txn_q;
    stall    = 1'b0;
    misalign = 1'b0;
    done     = 1'b0;
    bus_req  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (access && legal) begin
          state_d     = S_BUS;
          cnt_d       = '0;
          txn_d.addr  = {addr[31:2], 2'b00};
          txn_d.we    = mem_w;
          txn_d.be    = dm_be(dm_type, addr[1:0]);
          txn_d.wdata = dm_wrep(dm_type, wdata);
          txn_d.off   = addr[1:0];
          txn_d.typ   = dm_type;
          stall       = ~rst;
        end else if (access) begin
          misalign = ~rst;
        end
      end
      S_BUS: begin
        stall   = 1'b1;
        bus_req = 1'b1;
        if (bus_ack) begin
          state_d = S_DONE;
          if (!txn_q.we) rdata_d = ext;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rdata     = rdata_q;
  assign bus_err   = err_q;
  assign bus_we    = txn_q.we;
  assign bus_addr  = txn_q.addr;
  assign bus_be    = txn_q.be;
  assign bus_wdata = txn_q.wdata;

endmodule

// File: tb/tb_lsu_dm_port.sv
// Bench for lsu_dm_port: vector table plus hand
// sequences for wait states, timeout and reset.
module tb_lsu_dm_port;
  import lsu_dm_pkg::*;

  logic        clk, rst;
  logic        req_valid, mem_r, mem_w;
  logic [2:0]  dm_type;
  logic [31:0] addr, wdata;
  logic        stall, done, misalign, bus_err;
  logic [31:0] rdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  lsu_dm_port #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .mem_r(mem_r), .mem_w(mem_w),
    .dm_type(dm_type), .addr(addr), .wdata(wdata),
    .stall(stall), .done(done), .rdata(rdata),
    .misalign(misalign), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        mr, mw;
    logic [2:0]  dm;
    logic [31:0] addr, wdata, brd;
    int          wait_n;
    logic        mis;
    logic [3:0]  be;
    logic [31:0] bwd, rd;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] sb[$];
  logic [31:0] last_rd;
  int          n_chk, n_fail;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic mr, input logic mw, input logic [2:0] dm,
    input logic [31:0] a, input logic [31:0] wd,
    input logic [31:0] brd, input int wn, input logic mis,
    input logic [3:0] be, input logic [31:0] bwd,
    input logic [31:0] rd);
    vec_t v;
    v.mr = mr; v.mw = mw; v.dm = dm; v.addr = a;
    v.wdata = wd; v.brd = brd; v.wait_n = wn; v.mis = mis;
    v.be = be; v.bwd = bwd; v.rd = rd;
    return v;
  endfunction

  task automatic idle_inputs();
    req_valid = 1'b0; mem_r = 1'b0; mem_w = 1'b0;
    dm_type = 3'b000; addr = 32'h0; wdata = 32'h0;
  endtask

  task automatic drive(input vec_t v);
    req_valid = 1'b1; mem_r = v.mr; mem_w = v.mw;
    dm_type = v.dm; addr = v.addr; wdata = v.wdata;
  endtask

  task automatic do_access(input int id, input vec_t v);
    int sc;
    logic [31:0] exp_rd;
    @(negedge clk);
    drive(v);
    #1;
    if (v.mis) begin
      chk($sformatf("v%0d misalign", id), misalign, 1);
      chk($sformatf("v%0d mis stall", id), stall, 0);
      chk($sformatf("v%0d mis req", id), bus_req, 0);
      @(negedge clk);
      idle_inputs();
      #1;
      chk($sformatf("v%0d mis pulse", id), misalign, 0);
      chk($sformatf("v%0d mis req2", id), bus_req, 0);
      chk($sformatf("v%0d mis done", id), done, 0);
      chk($sformatf("v%0d mis rdata", id), rdata, last_rd);
      return;
    end
    chk($sformatf("v%0d no mis", id), misalign, 0);
    chk($sformatf("v%0d acc stall", id), stall, 1);
    sc = 1;
    exp_rd = (v.mr && !v.mw) ? v.rd : last_rd;
    sb.push_back(exp_rd);
    for (int n = 0; n <= v.wait_n; n++) begin
      @(negedge clk);
      req_valid = 1'b0;
      addr = $urandom;
      wdata = $urandom;
      dm_type = 3'($urandom_range(0, 4));
      bus_ack = (n == v.wait_n);
      bus_rdata = bus_ack ? v.brd : $urandom;
      #1;
      if (stall) sc++;
      chk($sformatf("v%0d req", id), bus_req, 1);
      chk($sformatf("v%0d we", id), bus_we, v.mw);
      chk($sformatf("v%0d be", id), bus_be, v.be);
      chk($sformatf("v%0d wdata", id), bus_wdata, v.bwd);
      chk($sformatf("v%0d baddr", id), bus_addr,
          {v.addr[31:2], 2'b00});
      chk($sformatf("v%0d early done", id), done, 0);
    end
    @(negedge clk);
    bus_ack = 1'b0;
    idle_inputs();
    #1;
    chk($sformatf("v%0d done", id), done, 1);
    chk($sformatf("v%0d done stall", id), stall, 0);
    chk($sformatf("v%0d req drop", id), bus_req, 0);
    chk($sformatf("v%0d stall cycles", id), sc, v.wait_n + 2);
    if (sb.size() == 0) begin
      chk($sformatf("v%0d sb empty", id), 1, 0);
    end else begin
      chk($sformatf("v%0d rdata", id), rdata, sb.pop_front());
    end
    last_rd = exp_rd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    n_chk = 0; n_fail = 0; last_rd = 32'h0;
    idle_inputs();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    rst = 1'b1;

    // sb/lb/lbu at 0x103, lh/lhu at 0x202, misaligned, wait states
    tbl.push_back(mk(0,1,DM_B ,32'h103,32'hA5,0,0,0,4'b1000,32'hA5A5A5A5,0));
    tbl.push_back(mk(1,0,DM_B ,32'h103,0,32'hA5000000,0,0,4'b1000,0,32'hFFFFFFA5));
    tbl.push_back(mk(1,0,DM_BU,32'h103,0,32'hA5000000,1,0,4'b1000,0,32'h000000A5));
    tbl.push_back(mk(1,0,DM_H ,32'h202,0,32'h80011234,0,0,4'b1100,0,32'hFFFF8001));
    tbl.push_back(mk(1,0,DM_HU,32'h202,0,32'h80011234,2,0,4'b1100,0,32'h00008001));
    tbl.push_back(mk(1,0,DM_W ,32'h101,0,0,0,1,0,0,0));
    tbl.push_back(mk(0,1,DM_H ,32'h003,32'h1,0,0,1,0,0,0));
    tbl.push_back(mk(0,1,DM_W ,32'h040,32'h12345678,0,4,0,4'b1111,32'h12345678,0));
    tbl.push_back(mk(1,0,DM_W ,32'h080,0,32'hDEADBEEF,0,0,4'b1111,0,32'hDEADBEEF));
    tbl.push_back(mk(1,0,DM_B ,32'h000,0,32'h0000007F,0,0,4'b0001,0,32'h0000007F));
    tbl.push_back(mk(1,0,DM_H ,32'h000,0,32'h0000FFFE,0,0,4'b0011,0,32'hFFFFFFFE));
    tbl.push_back(mk(1,0,3'b111,32'h000,0,0,0,1,0,0,0));
    tbl.push_back(mk(0,1,DM_H ,32'h102,32'h1234BEEF,0,1,0,4'b1100,32'hBEEFBEEF,0));
    tbl.push_back(mk(1,1,DM_W ,32'h044,32'hCAFEF00D,0,0,0,4'b1111,32'hCAFEF00D,0));
    tbl.push_back(mk(1,0,DM_BU,32'h101,0,32'h00008000,0,0,4'b0010,0,32'h00000080));
    tbl.push_back(mk(1,0,DM_HU,32'h201,0,0,0,1,0,0,0));

    // Reset values, with a request pending during reset
    repeat (2) @(negedge clk);
    req_valid = 1'b1; mem_r = 1'b1; addr = 32'h101;
    #1;
    chk("rst stall", stall, 0);
    chk("rst misalign", misalign, 0);
    chk("rst done", done, 0);
    chk("rst bus_err", bus_err, 0);
    chk("rst bus_req", bus_req, 0);
    chk("rst bus_we", bus_we, 0);
    chk("rst bus_be", bus_be, 0);
    chk("rst bus_addr", bus_addr, 0);
    chk("rst bus_wdata", bus_wdata, 0);
    chk("rst rdata", rdata, 0);
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;

    foreach (tbl[i]) do_access(i, tbl[i]);

    // bus_ack while idle is ignored
    @(negedge clk);
    bus_ack = 1'b1;
    bus_rdata = 32'h55555555;
    #1;
    chk("idle ack req", bus_req, 0);
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    chk("idle ack done", done, 0);
    chk("idle ack rdata", rdata, last_rd);

    // Request presented in DONE is ignored
    @(negedge clk);
    drive(mk(0,1,DM_W,32'h10,32'h1,0,0,0,0,0,0));
    @(negedge clk);
    idle_inputs();
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    drive(mk(1,0,DM_W,32'h20,0,0,0,0,0,0,0));
    #1;
    chk("done pulse", done, 1);
    chk("done stall", stall, 0);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("done ignored req", bus_req, 0);
    chk("done ignored stall", stall, 0);
    chk("done one cycle", done, 0);

    // Timeout: eight BUS cycles without ack
    @(negedge clk);
    drive(mk(1,0,DM_W,32'h30,0,0,0,0,0,0,0));
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      idle_inputs();
      #1;
      chk($sformatf("tmo req c%0d", k), bus_req, 1);
      chk($sformatf("tmo err c%0d", k), bus_err, 0);
    end
    @(negedge clk);
    #1;
    chk("tmo bus_err", bus_err, 1);
    chk("tmo req drop", bus_req, 0);
    chk("tmo stall", stall, 0);
    chk("tmo done", done, 0);
    chk("tmo rdata", rdata, last_rd);
    @(negedge clk);
    #1;
    chk("tmo err pulse", bus_err, 0);
    do_access(100, mk(1,0,DM_W,32'h34,0,32'h0BADF00D,0,0,4'b1111,0,32'h0BADF00D));

    // Reset in the second BUS cycle
    @(negedge clk);
    drive(mk(1,0,DM_W,32'h50,0,0,0,0,0,0,0));
    @(negedge clk);
    idle_inputs();
    #1;
    chk("mid rst bus1 req", bus_req, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid rst req", bus_req, 0);
    chk("mid rst stall", stall, 0);
    chk("mid rst rdata", rdata, 0);
    last_rd = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("mid rst no done %0d", k), done, 0);
    end
    do_access(101, mk(1,0,DM_B,32'h62,0,32'h00C30000,0,0,4'b0100,0,32'hFFFFFFC3));

    chk("sb drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
